matmul_seq: RTL and testbench
=============================

# matmul_seq

Cycle-level sequencer for the matrix-multiply accelerator. On a start command it walks the i/j/k loops of C = A·B for an N×N matrix, with N from 1 to 32. Each cycle it issues element read addresses to the A and B operand buffers, MAC control (clear/enable/last) to the single multiply-accumulate datapath, and write strobes to the C buffer. It replaces ad-hoc start-gated element copies with a fully pipelined, one-MAC-per-cycle schedule.

## Interface
Parameters:
- MAX_N, 32, largest supported matrix dimension.
- ADDR_W, 10, element address width (covers MAX_N² = 1024 elements, i.e. 256 words × 4 bytes).

Ports:
- clk  in  1  single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  begin a multiply; sampled only in IDLE.
- size_i  in  6  N, sampled with start_i.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle completion pulse.
- a_addr_o  out  ADDR_W  A element address, i·N+k.
- b_addr_o  out  ADDR_W  B element address, k·N+j.
- rd_o  out  1  A/B read strobe. Buffer data returns the next cycle.
- mac_en_o  out  1  accumulate the A·B product into the accumulator.
- mac_clr_o  out  1  with mac_en_o, load the product instead of adding it (k==0).
- mac_last_o  out  1  with mac_en_o, final term of the dot product (k==N-1).
- c_addr_o  out  ADDR_W  C element address, i·N+j.
- c_we_o  out  1  write the accumulator to C.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE -> RUN on start_i with a clamped size of at least 1. Latch N, zero i/j/k, set busy_o.
- IDLE -> DONE on start_i with size_i==0. No reads and no writes occur.
- Size clamp: size_i > MAX_N is treated as MAX_N.
- RUN: one read per cycle, rd_o=1.
  - k increments every cycle.
  - On k==N-1: k wraps to 0 and j increments. On j wrap, i increments.
  - After issuing (N-1, N-1, N-1) -> FLUSH.
- Address generation is incremental, with no multiplier:
  - a_addr_o: +1 per k; on k wrap it returns to the row base i·N.
  - b_addr_o: +N per k; on k wrap it returns to j+1. On j wrap it returns to 0.
  - c_addr_o: +1 per completed (i, j).
- Pipeline:
  - Stage 1 (MAC control): mac_en/clr/last is the one-cycle-delayed rd_o together with its k==0 / k==N-1 flags.
  - Stage 2 (write): c_we_o is the one-cycle-delayed mac_last_o, with c_addr_o held for that write.
- FLUSH: rd_o=0. Wait for the pipeline to drain; leave after the final c_we_o cycle -> DONE.
- DONE: done_o=1 for exactly one cycle, busy_o=0 -> IDLE.
- start_i is ignored while busy_o=1 or in DONE.
- Reset in any state: return to IDLE immediately and clear the pipeline flags. No further c_we_o occurs, and the partial C contents are undefined.

## Timing
- Reset values: busy_o=0, done_o=0, rd_o=0, mac_en_o=0, mac_clr_o=0, mac_last_o=0, c_we_o=0, all addresses 0.
- Reference timing: start accepted at edge 0.
- Reads are issued in cycles 1 .. N³, with no bubbles.
- mac_en_o is high in cycles 2 .. N³+1.
- c_we_o for output element e (0-based) occurs in cycle (e+1)·N+2.
- done_o occurs in cycle N³+3. A new start is accepted in cycle N³+4 at the earliest.
- N==0: done_o in cycle 1 after the start edge.

## Structure
- Package matmul_pkg: MAX_N, ADDR_W, the state enum type, and the clamp function for size.
- Sub-module matmul_addr_gen: the i/j/k counters, incremental A/B/C address registers, and the first/last flags. It is advanced by a single step_i input.
- matmul_seq holds the FSM, the 2-stage control pipeline, and busy/done generation.

## Test plan
- N=1: start -> a_addr=b_addr=0 with rd_o in cycle 1; mac_en+clr+last in cycle 2; c_we_o at c_addr 0 in cycle 3; done_o in cycle 4.
- N=2:
  - (a, b) address sequence (0,0)(1,2)(0,1)(1,3)(2,0)(3,2)(2,1)(3,3) in cycles 1–8.
  - c_we_o at c_addr 0, 1, 2, 3 in cycles 4, 6, 8, 10.
  - done_o in cycle 11.
  - Golden check against a software model of the C values using a behavioural buffer/MAC.
- N=32 full run: 32768 reads, 1024 writes, last write to c_addr 1023, done_o in cycle 32771. b_addr_o never exceeds 1023.
- size_i=0: done_o in cycle 1, no rd_o or c_we_o. size_i=40: behaves identically to size_i=32.
- start_i pulsed during RUN and in the DONE cycle: ignored, with no change to the address sequence. A start in the cycle after done_o is accepted.
- rst_n asserted during RUN of N=4 (cycle 20): all outputs return to reset values asynchronously, with no c_we_o afterwards. A subsequent N=2 start completes per the N=2 scenario.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants, FSM state type and size clamp for the matmul sequencer.
// No logic of its own; the clamp is purely combinational.
// No flow control lives here.
package matmul_pkg;

    localparam int MAX_N  = 32;
    localparam int ADDR_W = 10;
    localparam int SIZE_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Requested dimensions beyond the largest supported one are treated as that maximum.
    function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] s,
                                                     input logic [SIZE_W-1:0] lim);
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/matmul_addr_gen.sv
// i/j/k loop counters with incremental A/B/C element addresses (no multiplier).
// Addresses and flags reflect the current step; one step per cycle when step_i is high.
// No backpressure: the counters only move when the sequencer asserts step_i.
module matmul_addr_gen
    import matmul_pkg::*;
#(
    parameter int ADDR_W = matmul_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [SIZE_W-1:0] size_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] a_addr_o,
    output logic [ADDR_W-1:0] b_addr_o,
    output logic [ADDR_W-1:0] c_addr_o,
    output logic              k_first_o,
    output logic              k_last_o,
    output logic              final_o
);

    logic [SIZE_W-1:0] n_q, i_q, j_q, k_q;
    logic [SIZE_W-1:0] n_m1;
    logic [ADDR_W-1:0] row_q;
    logic [ADDR_W-1:0] n_w;
    logic              j_last, i_last;

    assign n_m1      = n_q - SIZE_W'(1);
    assign n_w       = ADDR_W'(n_q);
    assign k_first_o = (k_q == '0);
    assign k_last_o  = (k_q == n_m1);
    assign j_last    = (j_q == n_m1);
    assign i_last    = (i_q == n_m1);
    assign final_o   = k_last_o & j_last & i_last;

    // Walk k fastest, then j, then i; A rows restart at row_q, B columns restart at j+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            row_q    <= '0;
            a_addr_o <= '0;
            b_addr_o <= '0;
            c_addr_o <= '0;
        end else if (load_i) begin
            n_q      <= size_i;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            row_q    <= '0;
            a_addr_o <= '0;
            b_addr_o <= '0;
            c_addr_o <= '0;
        end else if (step_i) begin
            if (!k_last_o) begin
                k_q      <= k_q + SIZE_W'(1);
                a_addr_o <= a_addr_o + ADDR_W'(1);
                b_addr_o <= b_addr_o + n_w;
            end else begin
                k_q      <= '0;
                c_addr_o <= c_addr_o + ADDR_W'(1);
                if (!j_last) begin
                    j_q      <= j_q + SIZE_W'(1);
                    a_addr_o <= row_q;
                    b_addr_o <= ADDR_W'(j_q) + ADDR_W'(1);
                end else begin
                    j_q      <= '0;
                    i_q      <= i_last ? '0 : i_q + SIZE_W'(1);
                    row_q    <= row_q + n_w;
                    a_addr_o <= row_q + n_w;
                    b_addr_o <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/matmul_seq.sv
// Matrix-multiply sequencer: one A/B read per cycle, MAC control one cycle later, C write two later.
// Start to done_o is N^3+3 cycles; N==0 finishes in one cycle.
// No backpressure: start_i is only honoured in IDLE and ignored while busy or done.
module matmul_seq #(
    parameter int MAX_N  = matmul_pkg::MAX_N,
    parameter int ADDR_W = matmul_pkg::ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [matmul_pkg::SIZE_W-1:0] size_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [ADDR_W-1:0]             a_addr_o,
    output logic [ADDR_W-1:0]             b_addr_o,
    output logic                          rd_o,
    output logic                          mac_en_o,
    output logic                          mac_clr_o,
    output logic                          mac_last_o,
    output logic [ADDR_W-1:0]             c_addr_o,
    output logic                          c_we_o
);
    import matmul_pkg::*;

    state_t            state;
    logic [SIZE_W-1:0] size_c;
    logic              load;
    logic              k_first, k_last, final_step;
    logic [ADDR_W-1:0] gen_c_addr;
    logic [ADDR_W-1:0] c_addr_s1;

    assign size_c = clamp_size(size_i, SIZE_W'(MAX_N));
    assign load   = (state == ST_IDLE) && start_i;

    matmul_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .size_i    (size_c),
        .step_i    (rd_o),
        .a_addr_o  (a_addr_o),
        .b_addr_o  (b_addr_o),
        .c_addr_o  (gen_c_addr),
        .k_first_o (k_first),
        .k_last_o  (k_last),
        .final_o   (final_step)
    );

    // Control FSM with registered busy/done/read strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            rd_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (size_c == '0) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state  <= ST_RUN;
                            busy_o <= 1'b1;
                            rd_o   <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (final_step) begin
                        state <= ST_FLUSH;
                        rd_o  <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // The final C write is the last thing in flight.
                    if (c_we_o) begin
                        state  <= ST_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-stage control pipeline: MAC control trails the read by one cycle, the C write by two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_en_o   <= 1'b0;
            mac_clr_o  <= 1'b0;
            mac_last_o <= 1'b0;
            c_addr_s1  <= '0;
            c_we_o     <= 1'b0;
            c_addr_o   <= '0;
        end else begin
            mac_en_o   <= rd_o;
            mac_clr_o  <= rd_o & k_first;
            mac_last_o <= rd_o & k_last;
            if (rd_o) begin
                c_addr_s1 <= gen_c_addr;
            end
            c_we_o <= mac_last_o;
            if (mac_last_o) begin
                c_addr_o <= c_addr_s1;
            end
        end
    end

endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq: vector table of whole runs plus hand-written corner sequences.
// Each cycle is compared against an arithmetic schedule model; C values against a software product.
// Inputs change on the falling edge, outputs are sampled there too.
module tb_matmul_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [5:0] size_i = '0;
    logic       busy_o, done_o, rd_o, mac_en_o, mac_clr_o, mac_last_o, c_we_o;
    logic [9:0] a_addr_o, b_addr_o, c_addr_o;

    int tests = 0;
    int fails = 0;

    int amem [1024];
    int bmem [1024];
    int cmem [1024];

    always #5 clk = ~clk;

    matmul_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .size_i     (size_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .a_addr_o   (a_addr_o),
        .b_addr_o   (b_addr_o),
        .rd_o       (rd_o),
        .mac_en_o   (mac_en_o),
        .mac_clr_o  (mac_clr_o),
        .mac_last_o (mac_last_o),
        .c_addr_o   (c_addr_o),
        .c_we_o     (c_we_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 30) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill_mats();
        for (int e = 0; e < 1024; e++) begin
            amem[e] = int'($urandom_range(0, 15));
            bmem[e] = int'($urandom_range(0, 15));
            cmem[e] = -1;
        end
    endtask

    // One complete multiply, started from a falling edge in IDLE; returns at the falling edge of
    // the cycle after done_o, so a start driven by the caller right away lands in that cycle.
    task automatic run_case(input int sz, input bit pulse,
                            output int nreads, output int nwrites, output int last_c,
                            output int done_cyc, output int bmax);
        int n, n3, end_c, t, i, j, k, e, kk, pa, pb, acc;
        bit exp_rd, exp_en, exp_we;
        n = (sz > 32) ? 32 : sz;
        n3 = n * n * n;
        end_c = (n == 0) ? 1 : n3 + 3;
        nreads = 0; nwrites = 0; last_c = -1; done_cyc = 0; bmax = 0;
        pa = 0; pb = 0; acc = 0;
        fill_mats();
        start_i = 1'b1;
        size_i  = 6'(sz);
        @(posedge clk);
        for (int cyc = 1; cyc <= end_c; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (pulse) begin
                start_i = (cyc == end_c) ? 1'b1 : 1'($urandom_range(0, 1));
                size_i  = 6'($urandom_range(0, 63));
            end
            // C write takes the accumulator as it stood before this cycle's MAC.
            exp_we = (n > 0) && (cyc >= n + 2) && (cyc <= n3 + 2) && ((cyc - 2) % n == 0);
            chk("c_we", int'(c_we_o), int'(exp_we));
            if (exp_we) chk("c_addr", int'(c_addr_o), (cyc - 2) / n - 1);
            if (c_we_o) begin
                nwrites++;
                last_c = int'(c_addr_o);
                cmem[c_addr_o] = acc;
            end
            exp_en = (n > 0) && (cyc >= 2) && (cyc <= n3 + 1);
            chk("mac_en", int'(mac_en_o), int'(exp_en));
            if (exp_en) begin
                kk = (cyc - 2) % n;
                chk("mac_clr", int'(mac_clr_o), int'(kk == 0));
                chk("mac_last", int'(mac_last_o), int'(kk == n - 1));
            end
            if (mac_en_o) acc = (mac_clr_o ? 0 : acc) + amem[pa] * bmem[pb];
            exp_rd = (n > 0) && (cyc <= n3);
            chk("rd", int'(rd_o), int'(exp_rd));
            if (exp_rd) begin
                t = cyc - 1;
                k = t % n;
                j = (t / n) % n;
                i = t / (n * n);
                chk("a_addr", int'(a_addr_o), i * n + k);
                chk("b_addr", int'(b_addr_o), k * n + j);
            end
            if (rd_o) begin
                nreads++;
                pa = int'(a_addr_o);
                pb = int'(b_addr_o);
                if (pb > bmax) bmax = pb;
            end
            chk("busy", int'(busy_o), int'((n > 0) && (cyc <= n3 + 2)));
            if (done_o && done_cyc == 0) done_cyc = cyc;
        end
        @(negedge clk);
        chk("idle_rd", int'(rd_o), 0);
        chk("idle_busy", int'(busy_o), 0);
        chk("idle_done", int'(done_o), 0);
        start_i = 1'b0;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                e = 0;
                for (int q = 0; q < n; q++) e += amem[r * n + q] * bmem[q * n + c];
                chk("c_value", cmem[r * n + c], e);
            end
        end
    endtask

    typedef struct {
        int sz;
        bit pulse;
        int exp_reads;
        int exp_writes;
        int exp_last_c;
        int exp_done;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int nr, nw, lc, dc, bm, n;

        vecs[0] = '{1,  1'b0, 1,     1,    0,    4};
        vecs[1] = '{2,  1'b0, 8,     4,    3,    11};
        vecs[2] = '{0,  1'b0, 0,     0,    -1,   1};
        vecs[3] = '{3,  1'b1, 27,    9,    8,    30};
        vecs[4] = '{5,  1'b0, 125,   25,   24,   128};
        vecs[5] = '{32, 1'b0, 32768, 1024, 1023, 32771};
        vecs[6] = '{40, 1'b0, 32768, 1024, 1023, 32771};

        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_rd", int'(rd_o), 0);
        chk("rst_mac_en", int'(mac_en_o), 0);
        chk("rst_c_we", int'(c_we_o), 0);
        chk("rst_addr", int'(a_addr_o) + int'(b_addr_o) + int'(c_addr_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            run_case(vecs[v].sz, vecs[v].pulse, nr, nw, lc, dc, bm);
            chk("vec_reads", nr, vecs[v].exp_reads);
            chk("vec_writes", nw, vecs[v].exp_writes);
            chk("vec_last_c", lc, vecs[v].exp_last_c);
            chk("vec_done_cyc", dc, vecs[v].exp_done);
            if (vecs[v].sz > 0) chk("vec_bmax", bm, vecs[v].exp_writes - 1);
        end

        // Randomised sizes, each started in the cycle right after the previous done_o.
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 7));
            run_case(n, 1'($urandom_range(0, 1)), nr, nw, lc, dc, bm);
            chk("rnd_reads", nr, n * n * n);
            chk("rnd_writes", nw, n * n);
            chk("rnd_done_cyc", dc, n * n * n + 3);
        end

        // Asynchronous reset in the middle of an N=4 run.
        fill_mats();
        start_i = 1'b1;
        size_i  = 6'd4;
        @(posedge clk);
        for (int cyc = 1; cyc < 20; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        @(negedge clk);
        chk("pre_rst_busy", int'(busy_o), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_rd", int'(rd_o), 0);
        chk("arst_mac", int'(mac_en_o) + int'(mac_clr_o) + int'(mac_last_o), 0);
        chk("arst_c_we", int'(c_we_o), 0);
        chk("arst_addr", int'(a_addr_o) + int'(b_addr_o) + int'(c_addr_o), 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_c_we", int'(c_we_o), 0);
        end
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            chk("post_rst_c_we", int'(c_we_o), 0);
            chk("post_rst_busy", int'(busy_o), 0);
        end
        run_case(2, 1'b0, nr, nw, lc, dc, bm);
        chk("after_rst_writes", nw, 4);
        chk("after_rst_done_cyc", dc, 11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running at %0t, limit 2000000", $time);
        $fatal(1);
    end

endmodule
